// File: rtl/interrupt_sequencer.sv
// CPU-side interrupt entry/return sequencer: CALL/LOAD/RET handshake with a return-PC stack.
// Define INT_SEQ_NEST_EN to allow nested preemption up to DEPTH levels; otherwise one level.
module interrupt_sequencer #(
  parameter  int WIDTH = 8,
  parameter  int PC_W  = 10,
  parameter  int DEPTH = 8,
  localparam int NW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pend,
  input  logic [WIDTH-1:0] active,
  input  logic [PC_W-1:0]  vec_dir,
  input  logic [PC_W-1:0]  pc_next,
  input  logic             reti_instr,
  output logic [WIDTH-1:0] s_calli,
  output logic [WIDTH-1:0] s_reti,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_target,
  output logic             stall,
  output logic [NW-1:0]    nest_level,
  output logic             stack_ovf
);

  typedef enum logic [1:0] {IDLE, CALL, LOAD, RET} state_t;

  localparam logic [NW-1:0] ONE = NW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_calli_q, s_calli_d;
  logic [WIDTH-1:0] s_reti_q, s_reti_d;
  logic             pc_load_q, pc_load_d;
  logic [PC_W-1:0]  pc_target_q, pc_target_d;
  logic             stall_q, stall_d;
  logic [NW-1:0]    nest_q, nest_d;
  logic             ovf_q, ovf_d;

  logic             push;
  logic             prio_ok;
  logic             take_ok;
  logic             full;
  logic [PC_W-1:0]  top_pc;

`ifdef INT_SEQ_NEST_EN
  localparam logic [NW-1:0] CAP    = NW'(DEPTH);
  localparam logic          OVF_EN = 1'b1;
  localparam int            AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0] stack_q [DEPTH];
  logic [NW-1:0]   top_idx;

  // Both vectors are one-hot, so a numerically smaller value is a lower index.
  assign prio_ok = (active == '0) || (pend < active);
  assign top_idx = nest_q - ONE;
  assign top_pc  = stack_q[top_idx[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) stack_q[nest_q[AW-1:0]] <= pc_next;
  end
`else
  localparam logic [NW-1:0] CAP    = NW'(1);
  localparam logic          OVF_EN = 1'b0;

  logic [PC_W-1:0] stack_q;

  assign prio_ok = (active == '0);
  assign top_pc  = stack_q;

  always_ff @(posedge clk) begin
    if (push) stack_q <= pc_next;
  end
`endif

  assign take_ok = (pend != '0) && prio_ok;
  assign full    = (nest_q >= CAP);

  always_comb begin
    state_d     = state_q;
    s_calli_d   = '0;
    s_reti_d    = '0;
    pc_load_d   = 1'b0;
    pc_target_d = '0;
    stall_d     = 1'b0;
    nest_d      = nest_q;
    ovf_d       = ovf_q;
    push        = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A matched return wins over a simultaneous take.
        if (reti_instr && (nest_q != '0)) begin
          state_d     = RET;
          s_reti_d    = active;
          pc_load_d   = 1'b1;
          pc_target_d = top_pc;
          stall_d     = 1'b1;
        end else if (take_ok && !full) begin
          state_d   = CALL;
          s_calli_d = pend;
          stall_d   = 1'b1;
        end else if (take_ok) begin
          ovf_d = OVF_EN;
        end
      end
      CALL: begin
        state_d     = LOAD;
        push        = 1'b1;
        nest_d      = nest_q + ONE;
        pc_load_d   = 1'b1;
        pc_target_d = vec_dir;
        stall_d     = 1'b1;
      end
      LOAD: begin
        state_d = IDLE;
      end
      RET: begin
        state_d = IDLE;
        nest_d  = nest_q - ONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      s_calli_q   <= '0;
      s_reti_q    <= '0;
      pc_load_q   <= 1'b0;
      pc_target_q <= '0;
      stall_q     <= 1'b0;
      nest_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_calli_q   <= s_calli_d;
      s_reti_q    <= s_reti_d;
      pc_load_q   <= pc_load_d;
      pc_target_q <= pc_target_d;
      stall_q     <= stall_d;
      nest_q      <= nest_d;
      ovf_q       <= ovf_d;
    end
  end

  assign s_calli    = s_calli_q;
  assign s_reti     = s_reti_q;
  assign pc_load    = pc_load_q;
  assign pc_target  = pc_target_q;
  assign stall      = stall_q;
  assign nest_level = nest_q;
  assign stack_ovf  = ovf_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: a handler-stack model predicts timed output events.
module tb_interrupt_sequencer;
  localparam int WIDTH = 8;
  localparam int PC_W  = 10;
  localparam int DEPTH = 2;
  localparam int NW    = $clog2(DEPTH + 1);
`ifdef INT_SEQ_NEST_EN
  localparam bit NEST = 1'b1;
  localparam int CAP  = DEPTH;
`else
  localparam bit NEST = 1'b0;
  localparam int CAP  = 1;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] pend = '0;
  logic [WIDTH-1:0] active = '0;
  logic [PC_W-1:0]  vec_dir = '0;
  logic [PC_W-1:0]  pc_next = '0;
  logic             reti_instr = 1'b0;
  logic [WIDTH-1:0] s_calli;
  logic [WIDTH-1:0] s_reti;
  logic             pc_load;
  logic [PC_W-1:0]  pc_target;
  logic             stall;
  logic [NW-1:0]    nest_level;
  logic             stack_ovf;

  interrupt_sequencer #(.WIDTH(WIDTH), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pend(pend), .active(active), .vec_dir(vec_dir),
    .pc_next(pc_next), .reti_instr(reti_instr), .s_calli(s_calli), .s_reti(s_reti),
    .pc_load(pc_load), .pc_target(pc_target), .stall(stall),
    .nest_level(nest_level), .stack_ovf(stack_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] calli;
    logic [WIDTH-1:0] reti;
    logic             load;
    logic [PC_W-1:0]  tgt;
    int               at;
  } exp_t;

  exp_t             expq[$];
  int               svc[$];   // priority index of each handler in service, innermost last
  logic [PC_W-1:0]  rpc[$];   // return PC saved for each handler in service
  bit               ovf_m = 1'b0;
  int               checks = 0;
  int               errors = 0;

  function automatic logic [WIDTH-1:0] onehot(int i);
    logic [WIDTH-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(logic [WIDTH-1:0] v);
    for (int i = 0; i < WIDTH; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] cur_active();
    if (svc.size() == 0) return '0;
    return onehot(svc[svc.size()-1]);
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic exp_push(logic [WIDTH-1:0] c, logic [WIDTH-1:0] r, logic l,
                          logic [PC_W-1:0] t, int at);
    exp_t e;
    e.calli = c; e.reti = r; e.load = l; e.tgt = t; e.at = at;
    expq.push_back(e);
  endtask

  // Decide what one sampled IDLE edge does; 'at' is the cycle in which the first reaction shows.
  task automatic model_edge(logic [WIDTH-1:0] p, logic r, logic [PC_W-1:0] v,
                            logic [PC_W-1:0] pcv, int at);
    bit prio_ok;
    if (r && svc.size() > 0) begin
      exp_push('0, onehot(svc[svc.size()-1]), 1'b1, rpc[rpc.size()-1], at);
      void'(svc.pop_back());
      void'(rpc.pop_back());
    end else if (p != '0) begin
      prio_ok = (svc.size() == 0) || (NEST && idx_of(p) < svc[svc.size()-1]);
      if (prio_ok && svc.size() < CAP) begin
        exp_push(p, '0, 1'b0, '0, at);
        exp_push('0, '0, 1'b1, v, at + 1);
        svc.push_back(idx_of(p));
        rpc.push_back(pcv);
      end else if (prio_ok) begin
        ovf_m = 1'b1;
      end
    end
  endtask

  task automatic issue(logic [WIDTH-1:0] p, logic r, logic [PC_W-1:0] v, logic [PC_W-1:0] pcv);
    @(negedge clk);
    active = cur_active(); pend = p; reti_instr = r; vec_dir = v; pc_next = pcv;
    model_edge(p, r, v, pcv, cyc + 1);
    @(negedge clk);
    pend = '0; reti_instr = 1'b0; active = cur_active();
    repeat (3) @(negedge clk);
    check("nest_level", nest_level, svc.size());
    check("stack_ovf", stack_ovf, ovf_m);
  endtask

  // Monitor: every cycle with any handshake activity must match the next predicted event.
  always @(negedge clk) begin
    exp_t e;
    if (s_calli != '0 || s_reti != '0 || pc_load || stall) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output at cycle %0d: calli=%b reti=%b load=%b target=%h stall=%b",
                 cyc, s_calli, s_reti, pc_load, pc_target, stall);
      end else begin
        e = expq.pop_front();
        check("event_cycle", cyc, e.at);
        check("s_calli", s_calli, e.calli);
        check("s_reti", s_reti, e.reti);
        check("pc_load", pc_load, e.load);
        if (e.load) check("pc_target", pc_target, e.tgt);
        check("stall", stall, 1);
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s_calli", s_calli, 0);
    check("rst_s_reti", s_reti, 0);
    check("rst_pc_load", pc_load, 0);
    check("rst_pc_target", pc_target, 0);
    check("rst_stall", stall, 0);
    check("rst_nest_level", nest_level, 0);
    check("rst_stack_ovf", stack_ovf, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single entry and return
    issue(8'b0000_0100, 1'b0, 10'b1000000010, 10'h05A);
    check("single_nest", nest_level, 1);
    issue('0, 1'b1, 10'h000, 10'h000);
    check("single_return_nest", nest_level, 0);

    // Preemption, lower-priority request, stack-full request, then unwind
    issue(onehot(5), 1'b0, 10'h150, 10'h011);
    issue(8'b0000_0010, 1'b0, 10'h260, 10'h022);
    check("preempt_nest", nest_level, NEST ? 2 : 1);
    issue(8'b1000_0000, 1'b0, 10'h370, 10'h033);
    issue(8'b0000_0001, 1'b0, 10'h080, 10'h044);
    check("full_ovf", stack_ovf, NEST ? 1 : 0);
    while (svc.size() > 0) issue('0, 1'b1, 10'h000, 10'h000);
    check("ovf_sticky", stack_ovf, NEST ? 1 : 0);

    // Unmatched return
    @(negedge clk); reti_instr = 1'b1;
    @(negedge clk); reti_instr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("unmatched_s_reti", s_reti, 0);
      check("unmatched_pc_load", pc_load, 0);
      @(negedge clk);
    end

    // Return and take in the same IDLE cycle: return first, call after one IDLE cycle
    issue(onehot(3), 1'b0, 10'h111, 10'h0A0);
    @(negedge clk);
    active = cur_active(); pend = onehot(6); reti_instr = 1'b1;
    vec_dir = 10'h1C0; pc_next = 10'h0B0;
    model_edge(onehot(6), 1'b1, 10'h1C0, 10'h0B0, cyc + 1);
    @(negedge clk);
    reti_instr = 1'b0; active = cur_active();
    model_edge(onehot(6), 1'b0, 10'h1C0, 10'h0B0, cyc + 2);
    repeat (2) @(negedge clk);
    pend = '0; active = cur_active();
    repeat (3) @(negedge clk);
    check("simul_nest", nest_level, svc.size());
    while (svc.size() > 0) issue('0, 1'b1, 10'h000, 10'h000);

    // Reset during the CALL cycle
    @(negedge clk);
    active = cur_active(); pend = onehot(4); vec_dir = 10'h2F0; pc_next = 10'h0C0;
    exp_push(onehot(4), '0, 1'b0, '0, cyc + 1);
    @(negedge clk);
    pend = '0; reset = 1'b0;
    @(negedge clk);
    check("midrst_s_calli", s_calli, 0);
    check("midrst_s_reti", s_reti, 0);
    check("midrst_pc_load", pc_load, 0);
    check("midrst_pc_target", pc_target, 0);
    check("midrst_stall", stall, 0);
    check("midrst_nest", nest_level, 0);
    check("midrst_ovf", stack_ovf, 0);
    reset = 1'b1;
    svc.delete(); rpc.delete(); ovf_m = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_after_nest", nest_level, 0);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      logic [WIDTH-1:0] p;
      logic             r;
      p = ($urandom_range(0, 3) == 0) ? '0 : onehot($urandom_range(0, WIDTH - 1));
      r = ($urandom_range(0, 99) < 30);
      issue(p, r, PC_W'($urandom), PC_W'($urandom));
    end
    while (svc.size() > 0) issue('0, 1'b1, 10'h000, 10'h000);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
